uart_packet_deframer: RTL and testbench
=======================================

// Module: uart_packet_deframer
// PURPOSE
// Sits between the UART byte receiver (BT_RX side) and the NoC injection port of the secure platform.
// Parses the host packet format: HEADER(1B) ADDR(1B) SIZE(2B, little-endian) PAYLOAD(SIZE bytes).
// Emits a header flit, then payload packed into 32-bit flits, through a FIFO with valid/ready output.
// HEADER: 0 = LOOPBACK_RX, 1 = BOOT_RX, 3 = SCANF_RX.
// PARAMETERS
// FIFO_DEPTH     8        output flit FIFO depth in 33-bit entries (data + last); power of 2, >= 2
// TIMEOUT_CYCLES 100000   idle cycles mid-packet before the packet is aborted
// PORTS
// sys_clock    in   1   system clock; all logic is on the rising edge
// reset        in   1   asynchronous, active-high reset
// rx_data      in   8   received byte from the UART RX
// rx_valid     in   1   1-cycle strobe; rx_data is valid. No backpressure is possible.
// out_data     out  32  flit toward the NoC
// out_valid    out  1   FIFO is not empty
// out_last     out  1   final flit of the packet
// out_ready    in   1   consumer accepts the flit when out_valid && out_ready
// err_clear    in   1   1-cycle pulse; clears all sticky error flags
// err_type     out  1   sticky: an unsupported HEADER value was received
// err_overflow out  1   sticky: a flit was dropped because the FIFO was full
// err_timeout  out  1   sticky: a packet was aborted on timeout
// busy         out  1   FSM is not in IDLE
// BEHAVIOUR
// - Reset: FSM = IDLE; FIFO empty; all outputs = 0; timeout counter = 0; byte lane = 0.
// - FSM: IDLE -> ADDR -> SIZE_LO -> SIZE_HI -> PAYLOAD or DROP -> IDLE.
//   Each transition advances on one rx_valid.
// - IDLE: capture the HEADER byte.
// - SIZE_HI: complete the 16-bit SIZE.
//   - Valid type: push header flit {type[7:0], addr[7:0], size[15:0]}, with last = (size == 0).
//     Go to PAYLOAD, or to IDLE if size == 0.
//   - Invalid type: set err_type and go to DROP (or IDLE if size == 0). Nothing is pushed.
// - PAYLOAD packing:
//   - Bytes are packed little-endian: the first byte goes to [7:0].
//   - A flit is pushed after every 4th byte, and after the final byte (remaining = 0).
//   - Unused upper bytes of a partial final flit are 0. last = 1 only on the final flit.
// - DROP: discard SIZE bytes, then go to IDLE.
// - Byte counter: 16-bit down-counter of remaining bytes. A SIZE of 65535 must work (no wrap).
// - Push/pop:
//   - Push is combinational with the byte strobe (written at that edge). Pop occurs on out_valid && out_ready.
//   - Simultaneous push and pop on a full FIFO succeeds; occupancy is unchanged.
//   - out_data and out_last come from the FIFO head. Latency from the final byte's rx_valid to out_valid is 1 cycle when the FIFO was empty.
//   - Push to a full FIFO without a pop: the flit is dropped and err_overflow is set. Parsing continues.
// - Timeout counter:
//   - Clears on every rx_valid and in IDLE; otherwise increments while busy.
//   - On reaching TIMEOUT_CYCLES: set err_timeout and go to IDLE.
//   - If aborted in PAYLOAD: push the current partial flit (zero-padded; an all-zero flit if the lane is empty) with last = 1.
//   - If aborted in ADDR, SIZE_LO, SIZE_HI or DROP: nothing is pushed.
// - Errors: err_* set in the same cycle as err_clear wins over the clear.
// - Reset mid-packet: all state is discarded immediately (async). The FIFO contents are lost.
// - out_valid, out_data and out_last are stable while out_valid && !out_ready.
// TESTING
// 1. Send 03 08 08 00 04 03 02 01 08 07 06 05 with out_ready = 1.
//    -> flits 0x03080008, 0x01020304, 0x05060708; last = 1 on the third only. No errors.
// 2. Send 01 02 05 00 AA BB CC DD EE.
//    -> flits 0x01020005, 0xDDCCBBAA, 0x000000EE (last). busy = 0 after the final byte.
// 3. Send 00 04 00 00.
//    -> single flit 0x00040000 with last = 1. The FSM returns to IDLE.
// 4. Send 07 01 03 00 11 22 33, then scenario 1.
//    -> err_type = 1 and no flits for the first packet. Scenario 1 flits then follow exactly.
// 5. Hold out_ready = 0 with FIFO_DEPTH = 2 and send scenario 1.
//    -> 2 flits held, third dropped, err_overflow = 1. err_clear pulse -> 0.
// 6. Send 03 08 08 00 04 03, then idle for TIMEOUT_CYCLES.
//    -> flits 0x03080008, 0x00000304 (last), err_timeout = 1, busy = 0.
//    Repeat, asserting reset mid-packet -> outputs 0 and FIFO empty.

Source files
------------

// File: rtl/uart_packet_deframer_if.sv
// rtl/uart_packet_deframer_if.sv - byte input and flit output handshake bundle for the packet deframer
interface uart_packet_deframer_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;

   modport master (
      output rx_data, rx_valid, out_ready,
      input  out_data, out_valid, out_last
   );

   modport slave (
      input  rx_data, rx_valid, out_ready,
      output out_data, out_valid, out_last
   );
endinterface

// File: rtl/uart_packet_deframer.sv
// rtl/uart_packet_deframer.sv - parses UART host packets into header and 32-bit payload flits
module uart_packet_deframer #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   sys_clock,
   input  logic                   reset,
   uart_packet_deframer_if.slave  bus,
   input  logic                   err_clear,
   output logic                   err_type,
   output logic                   err_overflow,
   output logic                   err_timeout,
   output logic                   busy
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDR    = 3'd1;
   localparam logic [2:0] S_SIZE_LO = 3'd2;
   localparam logic [2:0] S_SIZE_HI = 3'd3;
   localparam logic [2:0] S_PAYLOAD = 3'd4;
   localparam logic [2:0] S_DROP    = 3'd5;

   logic [2:0]  state;
   logic [7:0]  hdr;
   logic [7:0]  addr;
   logic [7:0]  size_lo;
   logic [15:0] remaining;
   logic [1:0]  lane;
   logic [23:0] pack;
   logic [TW-1:0] tcnt;

   logic        type_ok;
   logic [15:0] size_full;
   logic [31:0] lane_word;
   logic        timeout_hit;
   logic        push;
   logic [31:0] push_data;
   logic        push_last;

   logic [32:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        pop;
   logic        wr_en;
   logic [32:0] head;

   assign type_ok     = (hdr == 8'd0) || (hdr == 8'd1) || (hdr == 8'd3);
   assign size_full   = {bus.rx_data, size_lo};
   // pack keeps unused lanes at zero, so OR-ing in the new byte yields a padded flit
   assign lane_word   = {8'b0, pack} | ({24'b0, bus.rx_data} << {lane, 3'b000});
   assign timeout_hit = (state != S_IDLE) && !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYCLES));
   assign busy        = (state != S_IDLE);

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_last = 1'b0;
      if (timeout_hit) begin
         if (state == S_PAYLOAD) begin
            push      = 1'b1;
            push_data = {8'b0, pack};
            push_last = 1'b1;
         end
      end else if (bus.rx_valid) begin
         if (state == S_SIZE_HI && type_ok) begin
            push      = 1'b1;
            push_data = {hdr, addr, size_full};
            push_last = (size_full == 16'd0);
         end else if (state == S_PAYLOAD && (lane == 2'd3 || remaining == 16'd1)) begin
            push      = 1'b1;
            push_data = lane_word;
            push_last = (remaining == 16'd1);
         end
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == (AW + 1)'(FIFO_DEPTH));
   assign pop   = !empty && bus.out_ready;
   assign wr_en = push && (!full || pop);
   assign head  = mem[rd_ptr[AW-1:0]];

   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? 32'd0 : head[31:0];
   assign bus.out_last  = !empty && head[32];

   always_ff @(posedge sys_clock) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         state        <= S_IDLE;
         hdr          <= '0;
         addr         <= '0;
         size_lo      <= '0;
         remaining    <= '0;
         lane         <= '0;
         pack         <= '0;
         tcnt         <= '0;
         err_type     <= 1'b0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;

         err_type     <= (bus.rx_valid && state == S_SIZE_HI && !type_ok) || (err_type && !err_clear);
         err_overflow <= (push && !wr_en) || (err_overflow && !err_clear);
         err_timeout  <= timeout_hit || (err_timeout && !err_clear);

         if (state == S_IDLE || bus.rx_valid || timeout_hit)
            tcnt <= '0;
         else
            tcnt <= tcnt + 1'b1;

         if (timeout_hit) begin
            state <= S_IDLE;
            lane  <= '0;
            pack  <= '0;
         end else if (bus.rx_valid) begin
            case (state)
               S_IDLE: begin
                  hdr   <= bus.rx_data;
                  state <= S_ADDR;
               end
               S_ADDR: begin
                  addr  <= bus.rx_data;
                  state <= S_SIZE_LO;
               end
               S_SIZE_LO: begin
                  size_lo <= bus.rx_data;
                  state   <= S_SIZE_HI;
               end
               S_SIZE_HI: begin
                  remaining <= size_full;
                  lane      <= '0;
                  pack      <= '0;
                  if (size_full == 16'd0) state <= S_IDLE;
                  else if (type_ok)       state <= S_PAYLOAD;
                  else                    state <= S_DROP;
               end
               S_PAYLOAD: begin
                  remaining <= remaining - 1'b1;
                  lane      <= lane + 1'b1;
                  if (lane == 2'd3 || remaining == 16'd1) pack <= '0;
                  else                                    pack <= lane_word[23:0];
                  if (remaining == 16'd1) begin
                     lane  <= '0;
                     state <= S_IDLE;
                  end
               end
               S_DROP: begin
                  remaining <= remaining - 1'b1;
                  if (remaining == 16'd1) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_packet_deframer.sv
// tb/tb_uart_packet_deframer.sv - scoreboard bench for uart_packet_deframer
module tb_uart_packet_deframer;
   localparam int DEPTH = 2;
   localparam int TMO   = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_clear = 1'b0;
   logic err_type, err_overflow, err_timeout, busy;

   uart_packet_deframer_if bus ();

   uart_packet_deframer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .sys_clock    (clk),
      .reset        (rst),
      .bus          (bus.slave),
      .err_clear    (err_clear),
      .err_type     (err_type),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_data[$];
   logic        exp_last[$];
   logic [7:0]  pkt[$];
   logic        exp_err_type = 1'b0;
   int          ready_mode = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: header flit, then payload in 4-byte little-endian chunks; a short
   // byte list stands for a packet cut off by timeout (partial flit flushed as last).
   task automatic model_pkt(input int keep);
      logic [32:0] f[$];
      logic [7:0]  typ;
      logic [15:0] sz;
      logic [31:0] w;
      int n, avail, nch;
      bit complete;
      n = pkt.size();
      if (n < 4) return;
      typ = pkt[0];
      sz  = {pkt[3], pkt[2]};
      if (!(typ == 8'd0 || typ == 8'd1 || typ == 8'd3)) begin
         exp_err_type = 1'b1;
         return;
      end
      f.push_back({(sz == 16'd0), typ, pkt[1], sz});
      avail    = n - 4;
      complete = (avail >= int'(sz));
      if (complete) avail = int'(sz);
      nch = complete ? (avail + 3) / 4 : avail / 4 + 1;
      for (int k = 0; k < nch; k++) begin
         w = '0;
         for (int j = 0; j < 4; j++)
            if (4 * k + j < avail) w[8*j +: 8] = pkt[4 + 4 * k + j];
         f.push_back({(k == nch - 1), w});
      end
      for (int k = 0; k < f.size() && k < keep; k++) begin
         exp_data.push_back(f[k][31:0]);
         exp_last.push_back(f[k][32]);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_pkt(input int gmax);
      for (int i = 0; i < pkt.size(); i++)
         send_byte(pkt[i], (i == pkt.size() - 1) ? 0 : $urandom_range(gmax, 0));
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 err_clear = 1'b1;
      @(posedge clk); #1 err_clear = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_data.size() != 0 || bus.out_valid) && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(name, {32'd0, exp_data.size()}, 64'd0);
   endtask

   initial begin
      int low = 0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: bus.out_ready = 1'b0;
            1: bus.out_ready = 1'b1;
            default: begin
               if (low >= 2) bus.out_ready = 1'b1;
               else          bus.out_ready = ($urandom_range(2, 0) != 0);
               low = bus.out_ready ? 0 : low + 1;
            end
         endcase
      end
   end

   logic        stall = 1'b0;
   logic [32:0] held;
   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall && bus.out_valid)
            chk("hold_stable", {31'd0, bus.out_last, bus.out_data}, {31'd0, held});
         if (bus.out_valid && bus.out_ready) begin
            if (exp_data.size() == 0) begin
               chk("unexpected_flit", {32'd0, bus.out_data}, 64'd0);
            end else begin
               chk("flit_data", {32'd0, bus.out_data}, {32'd0, exp_data.pop_front()});
               chk("flit_last", {63'd0, bus.out_last}, {63'd0, exp_last.pop_front()});
            end
         end
         stall = bus.out_valid && !bus.out_ready;
         held  = {bus.out_last, bus.out_data};
      end
   end

   initial begin
      bus.rx_data   = 8'd0;
      bus.rx_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
      chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
      chk("rst_errs", {61'd0, err_type, err_overflow, err_timeout}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      pkt = {8'h03, 8'h08, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
      model_pkt(99);
      send_pkt(0);
      wait_drain("scn1_drain");
      chk("scn1_errs", {61'd0, err_type, err_overflow, err_timeout}, 64'd0);

      pkt = {8'h01, 8'h02, 8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      model_pkt(99);
      send_pkt(2);
      chk("scn2_busy", {63'd0, busy}, 64'd0);
      wait_drain("scn2_drain");

      pkt = {8'h00, 8'h04, 8'h00, 8'h00};
      model_pkt(99);
      send_pkt(1);
      chk("scn3_latency", {63'd0, bus.out_valid}, 64'd1);
      chk("scn3_busy", {63'd0, busy}, 64'd0);
      wait_drain("scn3_drain");

      pkt = {8'h07, 8'h01, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
      model_pkt(99);
      send_pkt(1);
      chk("scn4_err_type", {63'd0, err_type}, {63'd0, exp_err_type});
      chk("scn4_busy", {63'd0, busy}, 64'd0);
      pkt = {8'h03, 8'h08, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
      model_pkt(99);
      send_pkt(0);
      wait_drain("scn4_drain");
      pulse_clear();
      exp_err_type = 1'b0;
      chk("scn4_err_cleared", {63'd0, err_type}, 64'd0);

      ready_mode = 2;
      for (int p = 0; p < 25; p++) begin
         int r, sz;
         r  = $urandom_range(9, 0);
         sz = $urandom_range(12, 0);
         pkt.delete();
         if (r == 9)      pkt.push_back(8'(4 + $urandom_range(250, 0)));
         else if (r < 3)  pkt.push_back(8'd0);
         else if (r < 6)  pkt.push_back(8'd1);
         else             pkt.push_back(8'd3);
         pkt.push_back(8'($urandom_range(255, 0)));
         pkt.push_back(8'(sz));
         pkt.push_back(8'd0);
         for (int i = 0; i < sz; i++) pkt.push_back(8'($urandom_range(255, 0)));
         model_pkt(99);
         send_pkt(3);
      end
      ready_mode = 1;
      wait_drain("rand_drain");
      chk("rand_err_type", {63'd0, err_type}, {63'd0, exp_err_type});
      chk("rand_no_overflow", {63'd0, err_overflow}, 64'd0);
      chk("rand_no_timeout", {63'd0, err_timeout}, 64'd0);
      pulse_clear();
      exp_err_type = 1'b0;

      ready_mode = 0;
      repeat (2) @(posedge clk);
      pkt = {8'h03, 8'h08, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
      model_pkt(DEPTH);
      send_pkt(0);
      chk("scn5_held_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("scn5_overflow", {63'd0, err_overflow}, 64'd1);
      pulse_clear();
      chk("scn5_overflow_clr", {63'd0, err_overflow}, 64'd0);
      ready_mode = 1;
      wait_drain("scn5_drain");

      pkt = {8'h03, 8'h08, 8'h08, 8'h00, 8'h04, 8'h03};
      model_pkt(99);
      send_pkt(0);
      chk("scn6_busy_mid", {63'd0, busy}, 64'd1);
      repeat (TMO + 10) @(posedge clk);
      #1;
      chk("scn6_timeout", {63'd0, err_timeout}, 64'd1);
      chk("scn6_busy", {63'd0, busy}, 64'd0);
      wait_drain("scn6_drain");

      ready_mode = 0;
      repeat (2) @(posedge clk);
      send_pkt(0);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rstmid_data", {32'd0, bus.out_data}, 64'd0);
      chk("rstmid_busy", {63'd0, busy}, 64'd0);
      chk("rstmid_errs", {61'd0, err_type, err_overflow, err_timeout}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      ready_mode = 1;
      repeat (20) @(posedge clk);
      #1;
      chk("rstmid_empty", {63'd0, bus.out_valid}, 64'd0);
      chk("final_queue", {32'd0, exp_data.size()}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
